// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX serializer and the RX parity checker.
//   tx_state_e : serializer states, one state per bit time
//   PAR_EVEN / PAR_ODD : encoding of the PAR_TYP select
//   frame_len  : number of Busy cycles per frame for a given width/parity
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Start bit + payload + optional parity + stop bit.
    function automatic int frame_len(input int data_width, input logic par_en);
        return data_width + 2 + (par_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator shared by the TX and RX paths.
//   data_i     : payload bits
//   par_typ_i  : PAR_EVEN or PAR_ODD
//   par_bit_o  : bit that makes payload+parity even (PAR_EVEN) or odd (PAR_ODD)
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int Data_Width = 8
) (
    input  logic [Data_Width-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    always_comb begin
        par_bit_o = (par_typ_i == PAR_EVEN) ? (^data_i) : ~(^data_i);
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte from the TX FIFO and sends
// start, data (LSB first), optional parity and stop bits. CLK is the baud
// clock, so every CLK cycle is one bit time.
//   CLK, RST   : baud clock, asynchronous active-high reset
//   P_DATA     : FIFO read data, valid while Data_Valid=1
//   Data_Valid : FIFO not empty
//   PAR_EN     : insert parity bit
//   PAR_TYP    : 0 even, 1 odd parity
//   RD_INC     : FIFO pop strobe (combinational, one cycle per accepted byte)
//   TX_OUT     : serial line, idle high (registered)
//   Busy       : high while a frame is on the line (registered)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int Data_Width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_Width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  RD_INC,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int              CNT_W   = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(Data_Width - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [Data_Width-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  par_bit;

    uart_parity_calc #(
        .Data_Width (Data_Width)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .par_bit_o (par_bit)
    );

    // Pop happens on the same edge the byte is latched; masked in reset so
    // the FIFO never loses a byte while the serializer is held.
    assign RD_INC = (state_q == IDLE) & Data_Valid & ~RST;
    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    // TX_OUT/Busy are registered from the *next* state so the line level
    // changes on the same edge as the state it belongs to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = 1'b1;
        busy_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d   = START;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    tx_d      = 1'b0;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = data_q[0];
            end
            DATA: begin
                if (cnt_q == CNT_MAX) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit;
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    tx_d  = data_q[cnt_d];
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                // Always pass through IDLE so Busy drops between frames.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    logic       CLK, RST;
    logic [7:0] P_DATA;
    logic       Data_Valid, PAR_EN, PAR_TYP;
    logic       RD_INC, TX_OUT, Busy;

    uart_tx_serializer #(.Data_Width(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .RD_INC     (RD_INC),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a frame is a list of line levels still to be shown.
    bit q[$];
    bit m_tx   = 1'b1;
    bit m_busy = 1'b0;

    // Observation bookkeeping.
    bit obs[$];
    int n_rd, n_rise, n_fall;
    bit prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] pack_obs();
        logic [31:0] v = '0;
        for (int i = 0; i < obs.size() && i < 32; i++) v[i] = obs[i];
        return v;
    endfunction

    function automatic bit par_of(input logic [7:0] d, input logic odd);
        // Bit that makes the total count of ones even (odd when odd=1).
        return bit'(($countones(d) + int'(odd)) % 2);
    endfunction

    // One bit time; called and returns at a negedge.
    task automatic cyc(input logic dv, input logic [7:0] d, input logic pe, input logic pt);
        chk("tx_out", {31'd0, TX_OUT}, {31'd0, m_tx});
        chk("busy",   {31'd0, Busy},   {31'd0, m_busy});
        if (Busy) obs.push_back(TX_OUT);
        if (Busy && !prev_busy) n_rise++;
        if (!Busy && prev_busy) n_fall++;
        prev_busy = Busy;
        Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
        #1;
        chk("rd_inc", {31'd0, RD_INC}, {31'd0, (!m_busy && dv)});
        if (RD_INC) n_rd++;
        @(posedge CLK);
        if (q.size() > 0) begin
            m_tx = q.pop_front(); m_busy = 1'b1;
        end else if (!m_busy && dv) begin
            q.push_back(1'b0);
            for (int i = 0; i < 8; i++) q.push_back(d[i]);
            if (pe) q.push_back(par_of(d, pt));
            q.push_back(1'b1);
            m_tx = q.pop_front(); m_busy = 1'b1;
        end else begin
            m_tx = 1'b1; m_busy = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic clr_obs();
        obs.delete(); n_rd = 0; n_rise = 0; n_fall = 0;
    endtask

    initial begin
        RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #12;
        chk("rst_tx",   {31'd0, TX_OUT}, 32'd1);
        chk("rst_busy", {31'd0, Busy},   32'd0);
        chk("rst_rd",   {31'd0, RD_INC}, 32'd0);
        @(negedge CLK);
        Data_Valid = 1'b0;
        RST = 1'b0;

        // Empty FIFO after reset: line idles.
        clr_obs();
        for (int i = 0; i < 50; i++) cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
        chk("empty_rd", n_rd, 0);
        chk("empty_busy", n_rise, 0);

        // Single A5 frame, no parity.
        clr_obs();
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("a5_len", obs.size(), 10);
        chk("a5_seq", pack_obs(), 32'b1101001010);
        chk("a5_rd", n_rd, 1);

        // Parity on 0x03, even then odd.
        for (int t = 0; t < 2; t++) begin
            clr_obs();
            cyc(1'b1, 8'h03, 1'b1, 1'(t));
            for (int i = 0; i < 13; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
            chk("par_len", obs.size(), 11);
            chk("par_bit", {31'd0, obs[9]}, t);
        end

        // Back-to-back 55 then AA with Data_Valid held.
        clr_obs();
        for (int i = 0; i < 24; i++)
            cyc(1'(n_rd < 2), (n_rd == 0) ? 8'h55 : 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("b2b_rd", n_rd, 2);
        chk("b2b_rise", n_rise, 2);
        chk("b2b_fall", n_fall, 2);
        chk("b2b_len", obs.size(), 20);

        // Inputs disturbed mid-frame must not affect the frame in flight.
        clr_obs();
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'hFF, 1'(i % 2 == 0), 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_len", obs.size(), 10);
        chk("mid_seq", pack_obs(), 32'b1001111000);
        chk("mid_rd", n_rd, 1);

        // Reset during data bit 4 of 0xE0 (bit 4 is 0).
        cyc(1'b1, 8'hE0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_tx", {31'd0, TX_OUT}, 32'd0);
        chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("async_tx", {31'd0, TX_OUT}, 32'd1);
        chk("async_busy", {31'd0, Busy}, 32'd0);
        chk("async_rd", {31'd0, RD_INC}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        q.delete(); m_tx = 1'b1; m_busy = 1'b0; prev_busy = 1'b0;
        clr_obs();
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_rd", n_rd, 0);
        chk("post_rst_busy", n_rise, 0);

        // Randomized traffic against the frame model.
        clr_obs();
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
